lcd_rgb_timing: RTL and testbench
=================================

# lcd_rgb_timing

Parallel-RGB timing generator for the MIL LCD path. Consumes a 24-bit pixel stream (valid/ready with start-of-frame) from the frame-buffer reader and produces LCD_DATA, LCD_ENABLE, LCD_RS_HSD (HSYNC) and LCD_RD_VSD (VSYNC) on the 30 MHz pixel clock. It frame-locks to the stream's start-of-frame marker, flags underflow, and resynchronises automatically.

## Interface
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 48, HSYNC width (clocks)
- H_BP, 40, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, VSYNC width (lines)
- V_BP, 29, vertical back porch (lines)

- vid_clk  in  1  pixel clock (clk_30m); all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- pix_data  in  24  RGB888 pixel, R in [23:16]
- pix_valid  in  1  pix_data valid
- pix_sop  in  1  qualifies pix_data as first pixel of a frame
- pix_ready  out  1  block accepts beat when pix_valid && pix_ready
- lcd_data  out  24  pixel to panel
- lcd_de  out  1  data enable, active high
- lcd_hs  out  1  HSYNC, active low
- lcd_vs  out  1  VSYNC, active low
- locked  out  1  high while in RUN
- underflow  out  1  one-cycle pulse per underflow/desync event

## Operation
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP); v_cnt 0..V_TOTAL-1, advances when h_cnt wraps; v_cnt wraps to 0. Counters free-run from reset regardless of state.
- Regions per axis: active [0, ACTIVE), front porch, sync, back porch in that order. active = h_active && v_active. Sync asserted when counter inside its sync window.
- States: WAIT (reset state), RUN.
- WAIT: pix_ready = 1 for beats without pix_sop (discarded). When a valid sop beat is presented, pix_ready = 0 (beat held) until (h_cnt,v_cnt) = (0,0); on that cycle pix_ready = 1, beat consumed, state -> RUN.
- RUN: pix_ready = active && !(pix_sop && (h_cnt,v_cnt) != (0,0)). Each active cycle consumes one beat.
- Underflow: in RUN, active cycle with pix_valid = 0 -> lcd_data = 0 for that pixel, underflow pulse, state -> WAIT.
- Desync: in RUN, pix_valid && pix_sop at active position other than (0,0) -> beat not consumed, lcd_data = 0, underflow pulse, state -> WAIT. A non-sop beat at (0,0) in RUN is displayed (no check).
- Output: lcd_de = active in both states; lcd_data = consumed pixel when RUN and beat accepted, else 0. Sync and DE generated in both states so the panel is always driven with valid timing.
- Simultaneous underflow and frame end: transition to WAIT takes priority; next sop locks at next (0,0).

## Timing
- All outputs registered: lcd_data/lcd_de/lcd_hs/lcd_vs/underflow reflect counter state of previous cycle (1-cycle latency from acceptance to lcd_data).
- pix_ready combinational from registered counters, state and pix_sop; no combinational path from pix_valid.
- Reset values: h_cnt = v_cnt = 0, state WAIT, lcd_data = 0, lcd_de = 0, lcd_hs = 1, lcd_vs = 1, locked = 0, underflow = 0, pix_ready = 0 while reset asserted.
- Reset mid-frame: all state cleared asynchronously; in-flight beat not consumed; first post-reset frame begins at (0,0) on first clock after release.
- locked rises the cycle after the sop beat is consumed; falls the cycle after underflow/desync.
- Widths: counters sized $clog2(TOTAL); all parameters ≥ 1.

## Test plan
Parameters for bench: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1 (H_TOTAL=7); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); frame = 42 clocks.
- Reset, no stream -> lcd_de high 4 of every 7 clocks on lines 0-2, lcd_hs low 1 clock at h_cnt=5 (observed one cycle later), lcd_vs low for all of line 4, lcd_data = 0, locked = 0.
- Always-valid stream of 12-pixel frames, sop on first, data = 0x000001..0x00000C -> sop held until (0,0), locked rises, lcd_data shows 1..12 during DE in order, repeats every 42 clocks, underflow never pulses.
- Deassert pix_valid for pixel 6 of a locked frame -> lcd_data = 0 for that DE cycle, one underflow pulse, locked falls, remaining beats discarded, relock on next sop.
- Inject sop at pixel 3 of a locked frame -> beat not consumed, underflow pulse, that sop beat displayed as first pixel of next frame.
- Non-sop beats before first sop after reset -> all accepted and discarded (pix_ready = 1), nothing displayed.
- Assert reset mid-line while locked -> outputs immediately at reset values; after release counters restart at (0,0), state WAIT.

Source files
------------

// File: rtl/lcd_rgb_timing.sv
// Parallel-RGB LCD timing generator.
// Free-running H/V counters drive DE and the active-low syncs; a small
// WAIT/RUN machine frame-locks the incoming pixel stream to (0,0) and
// drops back to WAIT on underflow or a misplaced start-of-frame.
module lcd_rgb_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29
) (
  input  logic        vid_clk,
  input  logic        reset,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sop,
  output logic        pix_ready,
  output logic [23:0] lcd_data,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        locked,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [23:0]   r_lcd_data;
  logic          r_lcd_de;
  logic          r_lcd_hs;
  logic          r_lcd_vs;
  logic          r_underflow;

  logic w_h_active;
  logic w_v_active;
  logic w_active;
  logic w_h_sync;
  logic w_v_sync;
  logic w_origin;
  logic w_ready;
  logic w_accept;
  logic w_err;

  assign w_h_active = (r_h_cnt < H_ACT_END);
  assign w_v_active = (r_v_cnt < V_ACT_END);
  assign w_active   = w_h_active && w_v_active;
  assign w_h_sync   = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
  assign w_v_sync   = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
  assign w_origin   = (r_h_cnt == '0) && (r_v_cnt == '0);

  // Underflow (missing beat) or start-of-frame at any active slot but (0,0).
  assign w_err    = (r_state == S_RUN) && w_active &&
                    (!pix_valid || (pix_sop && !w_origin));
  assign w_accept = pix_valid && w_ready;

  // Raster counters free-run from reset independent of lock state.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  // State register.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) r_state <= S_WAIT;
    else       r_state <= w_state_nxt;
  end

  // Next state: lock on consumed sop, fall back to WAIT on any stream error.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_WAIT) begin
      if (w_accept && pix_sop) w_state_nxt = S_RUN;
    end else begin
      if (w_err) w_state_nxt = S_WAIT;
    end
  end

  // Ready: WAIT flushes non-sop beats and holds a sop until (0,0); RUN takes
  // one beat per active slot but refuses a sop away from (0,0).
  always_comb begin
    w_ready = 1'b0;
    if (!reset) begin
      if (r_state == S_WAIT) w_ready = !pix_sop || w_origin;
      else                   w_ready = w_active && !(pix_sop && !w_origin);
    end
  end

  // Registered panel outputs; the sop beat consumed in WAIT is the first
  // displayed pixel, other WAIT beats are discarded.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      r_lcd_data  <= '0;
      r_lcd_de    <= 1'b0;
      r_lcd_hs    <= 1'b1;
      r_lcd_vs    <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_lcd_data  <= (w_accept && ((r_state == S_RUN) || pix_sop)) ? pix_data : '0;
      r_lcd_de    <= w_active;
      r_lcd_hs    <= !w_h_sync;
      r_lcd_vs    <= !w_v_sync;
      r_underflow <= w_err;
    end
  end

  assign pix_ready = w_ready;
  assign lcd_data  = r_lcd_data;
  assign lcd_de    = r_lcd_de;
  assign lcd_hs    = r_lcd_hs;
  assign lcd_vs    = r_lcd_vs;
  assign underflow = r_underflow;
  assign locked    = (r_state == S_RUN);

endmodule

// File: tb/tb_lcd_rgb_timing.sv
// Bench for lcd_rgb_timing with a tiny 7x6 raster (42-clock frame).
module tb_lcd_rgb_timing;

  localparam int HA = 4, HF = 1, HS = 1, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int NPIX = HA * VA;

  logic        vid_clk = 1'b0;
  logic        reset;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_sop;
  logic        pix_ready;
  logic [23:0] lcd_data;
  logic        lcd_de;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        locked;
  logic        underflow;

  always #5 vid_clk = ~vid_clk;

  lcd_rgb_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .vid_clk  (vid_clk),
    .reset    (reset),
    .pix_data (pix_data),
    .pix_valid(pix_valid),
    .pix_sop  (pix_sop),
    .pix_ready(pix_ready),
    .lcd_data (lcd_data),
    .lcd_de   (lcd_de),
    .lcd_hs   (lcd_hs),
    .lcd_vs   (lcd_vs),
    .locked   (locked),
    .underflow(underflow)
  );

  typedef struct {
    bit          sop;
    logic [23:0] data;
  } beat_t;

  beat_t q[$];
  int    disp_log[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference: raster position p (0..41) since reset release, plus lock flag.
  int p          = 0;
  bit m_run      = 0;
  bit stream_on  = 0;
  int frame_mode = 0;
  bit drop_armed = 0;
  bit drop_done  = 0;
  int under_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_active(input int pos);
    return ((pos % HT) < HA) && ((pos / HT) < VA);
  endfunction

  function automatic bit m_hsync(input int pos);
    return ((pos % HT) >= HA + HF) && ((pos % HT) < HA + HF + HS);
  endfunction

  function automatic bit m_vsync(input int pos);
    return ((pos / HT) >= VA + VF) && ((pos / HT) < VA + VF + VS);
  endfunction

  task automatic push_frame();
    beat_t b;
    for (int i = 0; i < NPIX; i++) begin
      b.sop  = (i == 0);
      b.data = (frame_mode == 0) ? 24'(i + 1) : 24'($urandom);
      q.push_back(b);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},  32'(lcd_data),  32'd0);
    check({tag, "_de"},    32'(lcd_de),    32'd0);
    check({tag, "_hs"},    32'(lcd_hs),    32'd1);
    check({tag, "_vs"},    32'(lcd_vs),    32'd1);
    check({tag, "_lock"},  32'(locked),    32'd0);
    check({tag, "_uf"},    32'(underflow), 32'd0);
    check({tag, "_ready"}, 32'(pix_ready), 32'd0);
  endtask

  // One pixel clock: called at posedge+1, returns at next posedge+1.
  task automatic step();
    bit v, s, mr, act, org, acc, e_uf, nrun;
    logic [23:0] d, e_data;
    act = m_active(p);
    org = (p == 0);
    if (stream_on) while (q.size() < 2 * NPIX) push_frame();
    v = 1'b0;
    s = 1'($urandom_range(0, 1));
    d = 24'($urandom);
    if (q.size() > 0 && !(!m_run && $urandom_range(0, 3) == 0)) begin
      v = 1'b1;
      s = q[0].sop;
      d = q[0].data;
    end
    if (drop_armed && v && m_run && act && !q[0].sop && q[0].data == 24'd6) begin
      v = 1'b0;
      s = 1'b0;
      drop_armed = 0;
      drop_done  = 1;
    end
    pix_valid = v;
    pix_sop   = s;
    pix_data  = d;
    #2;
    if (!m_run) mr = !s || org;
    else        mr = act && !(s && !org);
    check("pix_ready", 32'(pix_ready), 32'(mr));
    acc    = v && mr;
    e_uf   = m_run && act && (!v || (s && !org));
    e_data = (acc && (m_run || s)) ? d : 24'd0;
    nrun   = m_run ? !e_uf : (acc && s);
    if (acc) void'(q.pop_front());
    @(posedge vid_clk);
    #1;
    check("lcd_data",  32'(lcd_data),  32'(e_data));
    check("lcd_de",    32'(lcd_de),    32'(act));
    check("lcd_hs",    32'(lcd_hs),    32'(!m_hsync(p)));
    check("lcd_vs",    32'(lcd_vs),    32'(!m_vsync(p)));
    check("underflow", 32'(underflow), 32'(e_uf));
    check("locked",    32'(locked),    32'(nrun));
    m_run = nrun;
    p = (p + 1) % FT;
    if (lcd_de && locked) disp_log.push_back(int'(lcd_data));
    if (underflow) under_cnt++;
  endtask

  task automatic run_until_locked(input string tag, input int budget);
    int n = 0;
    while (!m_run && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(locked), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int de_hi, hs_lo, vs_lo, n;
    beat_t b;
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_sop   = 1'b0;
    pix_data  = '0;
    #1;
    check_reset_vals("rst0");
    repeat (2) @(posedge vid_clk);
    #1;
    check_reset_vals("rst1");
    reset = 1'b0;
    p = 0;
    m_run = 0;

    // Idle raster: two frames with no stream.
    de_hi = 0; hs_lo = 0; vs_lo = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      if (lcd_de) de_hi++;
      if (!lcd_hs) hs_lo++;
      if (!lcd_vs) vs_lo++;
    end
    check("idle_de_count", 32'(de_hi), 32'(2 * NPIX));
    check("idle_hs_count", 32'(hs_lo), 32'(2 * VT * HS));
    check("idle_vs_count", 32'(vs_lo), 32'(2 * HT * VS));

    // Noise beats ahead of the first sop, then incrementing frames.
    for (int i = 0; i < 5; i++) begin
      b.sop  = 1'b0;
      b.data = 24'($urandom_range(1, 24'hFFFFFF));
      q.push_back(b);
    end
    stream_on  = 1;
    frame_mode = 0;
    run_until_locked("lock1", 150);
    while (p != 0) step();
    disp_log.delete();
    under_cnt = 0;
    for (int i = 0; i < 2 * FT; i++) step();
    check("frames_pix_count", 32'(disp_log.size()), 32'(2 * NPIX));
    for (int i = 0; i < disp_log.size(); i++)
      check("frames_pix_value", 32'(disp_log[i]), 32'((i % NPIX) + 1));
    check("frames_no_uf", 32'(under_cnt), 32'd0);

    // Underflow on pixel 6, then relock.
    drop_armed = 1;
    drop_done  = 0;
    under_cnt  = 0;
    n = 0;
    while (!drop_done && n < 100) begin
      step();
      n++;
    end
    for (int i = 0; i < 2 * FT; i++) step();
    check("drop_uf_count", 32'(under_cnt), 32'd1);
    run_until_locked("lock_after_drop", 100);

    // Misplaced sop at pixel 3; it leads the next frame.
    n = 0;
    while (!(m_run && m_active(p) && q.size() > 0 && !q[0].sop && q[0].data == 24'd3) && n < 200) begin
      step();
      n++;
    end
    while (q.size() > 0 && !q[0].sop) void'(q.pop_front());
    for (int i = 0; i < NPIX - 1; i++) begin
      b.sop  = 1'b0;
      b.data = 24'($urandom);
      q.push_front(b);
    end
    b.sop  = 1'b1;
    b.data = 24'hABCDEF;
    q.push_front(b);
    disp_log.delete();
    under_cnt = 0;
    for (int i = 0; i < 3 * FT; i++) step();
    check("desync_uf_count", 32'(under_cnt), 32'd1);
    check("desync_log_nonempty", 32'(disp_log.size() > 0), 32'd1);
    if (disp_log.size() > 0) check("desync_first_pix", 32'(disp_log[0]), 32'hABCDEF);

    // Asynchronous reset mid-line while locked.
    n = 0;
    while (!(m_run && (p % HT) == 2 && (p / HT) == 1) && n < 100) begin
      step();
      n++;
    end
    pix_valid = 1'b1;
    pix_sop   = q[0].sop;
    pix_data  = q[0].data;
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst0");
    repeat (2) @(posedge vid_clk);
    #1;
    check_reset_vals("midrst1");
    reset = 1'b0;
    p = 0;
    m_run = 0;
    frame_mode = 1;
    run_until_locked("lock_after_reset", 150);
    for (int i = 0; i < 2 * FT; i++) step();
    check("final_locked", 32'(locked), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
